// File: rtl/anemometre_in_pio.sv
// -----------------------------------------------------------------------------
// anemometre_in_pio
//   Avalon-MM slave input PIO for the anemometer SOPC. External inputs are
//   synchronised, edges are captured into a sticky write-1-to-clear register,
//   and a maskable level interrupt is raised to the Nios II.
//
//   Register map (32-bit words, unused upper bits read 0):
//     0 DATA  RO     synchronised in_port
//     1 DIR   RO     always 0 (input-only)
//     2 MASK  RW     irq_mask[WIDTH-1:0]
//     3 EDGE  R/W1C  edge_capture[WIDTH-1:0]
//
//   Ports:
//     clk, reset_n      system clock / asynchronous active-low reset
//     address[1:0]      register word address
//     chipselect        slave select
//     write_n           active-low write strobe, qualified by chipselect
//     writedata[31:0]   write data
//     in_port[WIDTH-1:0] asynchronous external inputs
//     readdata[31:0]    registered read data, latency 1
//     irq               level interrupt, active high
// -----------------------------------------------------------------------------
module anemometre_in_pio #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int PW        = $clog2(PRIME_MAX + 1);
    localparam logic [PW-1:0] PRIME_DONE = PW'(PRIME_MAX);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_DIR  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q,  prev_d;
    logic [WIDTH-1:0] mask_q,  mask_d;
    logic [WIDTH-1:0] edge_q,  edge_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [PW-1:0]    prime_q, prime_d;

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] rise, fall, new_edges, clr_bits;
    logic             wr_en;
    logic [31:0]      data_ext, mask_ext, edge_ext;
    logic             unused_wdata;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign wr_en    = chipselect & ~write_n;
    // Only writedata[WIDTH-1:0] is meaningful; fold the rest into a sink.
    assign unused_wdata = ^writedata;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned
        // (otherwise a latch is inferred).
        for (int i = 0; i < SYNC_STAGES; i++) sync_d[i] = '0;
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];

        prev_d = sync_out;

        // Priming counter saturates; until then levels present at reset release
        // are still walking through the chain and must not look like edges.
        prime_d = (prime_q == PRIME_DONE) ? prime_q : prime_q + 1'b1;

        rise = sync_out & ~prev_q;
        fall = ~sync_out & prev_q;
        case (EDGE_TYPE)
            0:       new_edges = rise;
            1:       new_edges = fall;
            default: new_edges = rise | fall;
        endcase
        if (prime_q != PRIME_DONE) new_edges = '0;

        clr_bits = '0;
        if (wr_en && address == ADDR_EDGE) clr_bits = writedata[WIDTH-1:0];
        // A new edge on a bit being cleared in the same cycle wins.
        edge_d = (edge_q & ~clr_bits) | new_edges;

        mask_d = mask_q;
        if (wr_en && address == ADDR_MASK) mask_d = writedata[WIDTH-1:0];

        data_ext = '0;
        mask_ext = '0;
        edge_ext = '0;
        data_ext[WIDTH-1:0] = sync_out;
        mask_ext[WIDTH-1:0] = mask_q;
        edge_ext[WIDTH-1:0] = edge_q;

        rdata_d = '0;
        if (chipselect) begin
            case (address)
                ADDR_DATA: rdata_d = data_ext;
                ADDR_DIR:  rdata_d = '0;
                ADDR_MASK: rdata_d = mask_ext;
                ADDR_EDGE: rdata_d = edge_ext;
                default:   rdata_d = '0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q  <= '0;
            mask_q  <= '0;
            edge_q  <= '0;
            rdata_q <= '0;
            prime_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            prev_q  <= prev_d;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            rdata_q <= rdata_d;
            prime_q <= prime_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_anemometre_in_pio.sv
// -----------------------------------------------------------------------------
// tb_anemometre_in_pio
//   Self-checking bench for anemometre_in_pio. Three instances share the bus
//   and inputs: rising (main), falling and any-edge capture. Register reads go
//   through a scoreboard queue: the expected word is pushed when the address is
//   presented and popped when readdata becomes valid one cycle later.
// -----------------------------------------------------------------------------
module tb_anemometre_in_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_rise, rd_fall, rd_any;
    logic        irq_rise, irq_fall, irq_any;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    typedef struct {
        int          sel;   // 0 rise, 1 fall, 2 any
        logic [31:0] exp;
        string       name;
    } rd_exp_t;

    rd_exp_t sb[$];

    always #5 clk = ~clk;

    anemometre_in_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_rise), .irq(irq_rise));

    anemometre_in_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_fall), .irq(irq_fall));

    anemometre_in_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_any), .irq(irq_any));

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        write_n    = 1'b1;
        chipselect = 1'b0;
        writedata  = '0;
    endtask

    // Presents a read, queues the expectation, then compares after the edge.
    task automatic bus_read(input int sel, input logic [1:0] a,
                            input logic [31:0] exp, input string nm);
        rd_exp_t e;
        logic [31:0] got;
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        e.sel  = sel;
        e.exp  = exp;
        e.name = nm;
        sb.push_back(e);
        tick();
        e   = sb.pop_front();
        got = (e.sel == 0) ? rd_rise : (e.sel == 1) ? rd_fall : rd_any;
        chk_cnt++;
        if (got !== e.exp)
            $display("FAIL %s: readdata=0x%08h expected 0x%08h", e.name, got, e.exp);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        in_port    = 8'hFF;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        ticks(2);
        chk_cnt++;
        if (rd_rise !== 32'h0 || irq_rise !== 1'b0)
            $display("FAIL reset_state: readdata=0x%08h irq=%b expected 0 0", rd_rise, irq_rise);
        else
            pass_cnt++;
        reset_n = 1'b1;
        // Unmask everything during priming so any spurious capture shows on irq.
        bus_write(2'd2, 32'hFF);
        for (int i = 0; i < 6; i++) begin
            chk_cnt++;
            if (irq_rise !== 1'b0 || irq_any !== 1'b0)
                $display("FAIL prime_irq[%0d]: irq_rise=%b irq_any=%b expected 0 0", i, irq_rise, irq_any);
            else
                pass_cnt++;
            tick();
        end
        bus_read(0, 2'd0, 32'h0000_00FF, "reset_data");
        bus_read(0, 2'd3, 32'h0000_0000, "reset_edge_rise");
        bus_read(2, 2'd3, 32'h0000_0000, "reset_edge_any");
        chipselect = 1'b0;
    endtask

    task automatic test_rising_edge();
        bus_write(2'd2, 32'h01);
        in_port = 8'h00;
        ticks(4);
        bus_read(0, 2'd3, 32'h0, "fall_ignored_by_rise");
        chipselect = 1'b0;
        in_port = 8'h01;
        ticks(2);
        chk_cnt++;
        if (irq_rise !== 1'b0) $display("FAIL rise_early: irq=%b expected 0", irq_rise);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (irq_rise !== 1'b1) $display("FAIL rise_latency: irq=%b expected 1", irq_rise);
        else pass_cnt++;
        bus_read(0, 2'd3, 32'h01, "rise_edge");
        bus_write(2'd3, 32'h01);
        chk_cnt++;
        if (irq_rise !== 1'b0) $display("FAIL rise_clear_irq: irq=%b expected 0", irq_rise);
        else pass_cnt++;
        bus_read(0, 2'd3, 32'h00, "rise_cleared");
        chipselect = 1'b0;
    endtask

    task automatic test_masking();
        bus_write(2'd2, 32'h00);
        in_port = 8'h09;
        tick();
        in_port = 8'h01;
        ticks(4);
        chk_cnt++;
        if (irq_rise !== 1'b0) $display("FAIL masked_irq: irq=%b expected 0", irq_rise);
        else pass_cnt++;
        bus_read(0, 2'd3, 32'h08, "masked_edge");
        bus_write(2'd2, 32'h08);
        chk_cnt++;
        if (irq_rise !== 1'b1) $display("FAIL unmask_irq: irq=%b expected 1", irq_rise);
        else pass_cnt++;
    endtask

    task automatic test_clear_collision();
        bus_write(2'd3, 32'h08);
        bus_write(2'd2, 32'h04);
        chk_cnt++;
        if (irq_rise !== 1'b0) $display("FAIL pre_collision_irq: irq=%b expected 0", irq_rise);
        else pass_cnt++;
        in_port = 8'h05;
        ticks(2);
        // This write lands on the edge where the new bit-2 edge is captured.
        bus_write(2'd3, 32'h04);
        chk_cnt++;
        if (irq_rise !== 1'b1) $display("FAIL collision_irq: irq=%b expected 1", irq_rise);
        else pass_cnt++;
        bus_read(0, 2'd3, 32'h04, "collision_edge");
        chipselect = 1'b0;
    endtask

    task automatic test_edge_types();
        bus_write(2'd3, 32'hFF);
        in_port = 8'h85;
        ticks(4);
        bus_read(0, 2'd3, 32'h80, "rise_on_01");
        bus_read(2, 2'd3, 32'h80, "any_on_01");
        bus_read(1, 2'd3, 32'h00, "fall_on_01");
        bus_write(2'd3, 32'h80);
        in_port = 8'h05;
        ticks(4);
        bus_read(0, 2'd3, 32'h00, "rise_on_10");
        bus_read(2, 2'd3, 32'h80, "any_on_10");
        bus_read(1, 2'd3, 32'h80, "fall_on_10");
        chipselect = 1'b0;
    endtask

    task automatic test_bus();
        bus_write(2'd0, 32'h0);
        bus_read(0, 2'd0, 32'h05, "data_write_ignored");
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(0, 2'd1, 32'h0, "dir_reads_zero");
        bus_write(2'd2, 32'hFFFF_FFFF);
        // Back-to-back reads keep chipselect high across both.
        bus_read(0, 2'd2, 32'h0000_00FF, "mask_upper_zero");
        bus_read(0, 2'd0, 32'h0000_0005, "back_to_back_data");
        chipselect = 1'b0;
        tick();
        chk_cnt++;
        if (rd_rise !== 32'h0) $display("FAIL cs_low_zero: readdata=0x%08h expected 0", rd_rise);
        else pass_cnt++;
        chipselect = 1'b1;
        address    = 2'd2;
        #1;
        chk_cnt++;
        if (rd_rise !== 32'h0) $display("FAIL read_latency_pre: readdata=0x%08h expected 0", rd_rise);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (rd_rise !== 32'hFF) $display("FAIL read_latency_post: readdata=0x%08h expected 0x000000ff", rd_rise);
        else pass_cnt++;
        chipselect = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus_write(2'd3, 32'hFF);
        in_port = 8'h25;
        ticks(4);
        chk_cnt++;
        if (irq_rise !== 1'b1) $display("FAIL mid_pre_irq: irq=%b expected 1", irq_rise);
        else pass_cnt++;
        reset_n = 1'b0;
        #1;
        chk_cnt++;
        if (irq_rise !== 1'b0) $display("FAIL mid_async_irq: irq=%b expected 0", irq_rise);
        else pass_cnt++;
        tick();
        reset_n = 1'b1;
        bus_write(2'd2, 32'hFF);
        ticks(5);
        chk_cnt++;
        if (irq_rise !== 1'b0) $display("FAIL mid_reprime_irq: irq=%b expected 0", irq_rise);
        else pass_cnt++;
        bus_read(0, 2'd3, 32'h00, "mid_edge_cleared");
        bus_read(0, 2'd0, 32'h25, "mid_data");
        chipselect = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rising_edge();
        test_masking();
        test_clear_collision();
        test_edge_types();
        test_bus();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
